ascon_dom_round_scheduler: RTL

Sequences the rounds of the two-share DOM ASCON permutation datapath for one p^a, p^b or p^N call. It issues round-constant indices and the state-register commit enable. It also gates consumption of the 320-bit fresh-randomness word via a valid/ready handshake with the PRNG, stalling the datapath when randomness is unavailable. It sits between the AEAD controller, which issues perm_start, and the DOM datapath, which receives rcinit, round_en and passthrough_en.

---
 rtl/ascon_dom_pkg.sv | 16 +
 rtl/ascon_dom_round_scheduler.sv | 111 +++++++++++
 2 files changed

// File: rtl/ascon_dom_pkg.sv
// Shared types and constants for the two-share DOM ASCON permutation control path.
package ascon_dom_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RND_A = 2'd1,
    RND_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_ROUNDS = 12;
  localparam int PA_ROUNDS  = 12;
  localparam int PB_ROUNDS  = 6;
  localparam int RAND_W     = 320;

endpackage

// File: rtl/ascon_dom_round_scheduler.sv
// Round sequencer for the DOM ASCON permutation: issues round-constant indices and
// commit enables, and paces DOM rounds on the PRNG valid/ready handshake.
module ascon_dom_round_scheduler
  import ascon_dom_pkg::*;
#(
  parameter int MAX_ROUNDS = ascon_dom_pkg::MAX_ROUNDS,
  parameter int DOM_PHASES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       perm_start,
  input  logic [3:0] perm_rounds,
  input  logic       dom_en,
  input  logic       rand_valid,
  output logic       rand_ready,
  output logic [3:0] rcinit,
  output logic       round_en,
  output logic       passthrough_en,
  output logic       dom_phase,
  output logic       busy,
  output logic       perm_done,
  output logic [3:0] round_cnt,
  output logic       err
);

  localparam int PHASE_W = (DOM_PHASES > 1) ? $clog2(DOM_PHASES) : 1;
  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  state_t     state;
  logic [3:0] rc;
  logic [3:0] remaining;
  logic       dom_q;
  logic       err_q;
  logic       legal;
  logic       in_round;
  logic [PHASE_W-1:0] phase;

  assign legal    = (perm_rounds != 4'd0) && (perm_rounds <= MAX_R);
  assign in_round = (state == RND_A) || (state == RND_B);
  assign phase    = PHASE_W'(state == RND_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rc        <= 4'd0;
      remaining <= 4'd0;
      dom_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (perm_start) begin
            if (legal) begin
              rc        <= MAX_R - perm_rounds;
              remaining <= perm_rounds;
              dom_q     <= dom_en;
              state     <= RND_A;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RND_A: begin
          if (!dom_q) begin
            // Unmasked rounds commit every cycle; clear counters after the last one
            // so rc never steps past the final constant.
            if (remaining == 4'd1) begin
              rc        <= 4'd0;
              remaining <= 4'd0;
              state     <= DONE;
            end else begin
              rc        <= rc + 4'd1;
              remaining <= remaining - 4'd1;
            end
          end else if (rand_valid) begin
            state <= RND_B;
          end
        end
        RND_B: begin
          if (remaining == 4'd1) begin
            rc        <= 4'd0;
            remaining <= 4'd0;
            state     <= DONE;
          end else begin
            rc        <= rc + 4'd1;
            remaining <= remaining - 4'd1;
            state     <= RND_A;
          end
        end
        DONE: begin
          dom_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The word is taken only in the share-multiply cycle of a masked round.
  assign rand_ready     = (state == RND_A) && dom_q && rand_valid;
  assign round_en       = ((state == RND_A) && !dom_q) || (state == RND_B);
  assign passthrough_en = !in_round;
  assign dom_phase      = phase[0];
  assign busy           = in_round;
  assign perm_done      = (state == DONE);
  assign rcinit         = in_round ? rc : 4'd0;
  assign round_cnt      = in_round ? remaining : 4'd0;
  assign err            = err_q;

endmodule
